// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the occupancy-count width helper used by the design and benches.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 256;

  // Count needs one extra bit over the pointer so that DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned FIFO_CNT_W = cnt_width(FIFO_DEPTH);

endpackage

// File: rtl/RAM_2Port.sv
// Simple dual-port RAM: one write port, one registered read port whose output register can be reset.
// Array contents are never cleared; only the read output register is.
module RAM_2Port #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     i_wr_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_clk,
  input  logic                     i_rd_rst,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_wr_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register holds its value between reads.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with live almost-full/almost-empty thresholds and one-cycle read latency.
// Optional sticky overflow/underflow outputs when FIFO_SYNC_ERR_FLAGS_EN is defined.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_dv,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic [cnt_width(DEPTH)-1:0] i_af_level,
  output logic                        o_af_flag,
  output logic                        o_full,
  input  logic                        i_rd_en,
  input  logic [cnt_width(DEPTH)-1:0] i_ae_level,
  output logic                        o_ae_flag,
  output logic                        o_empty,
  output logic                        o_rd_dv,
  output logic [WIDTH-1:0]            o_rd_data
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  ,
  output logic                        o_overflow,
  output logic                        o_underflow
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rd_dv_q;
  logic             wr_acc;
  logic             rd_acc;

  // Status flags come from the registered count; thresholds are compared live.
  assign o_full    = (count == CNT_W'(DEPTH));
  assign o_empty   = (count == '0);
  assign o_af_flag = (count >= i_af_level);
  assign o_ae_flag = (count <= i_ae_level);

  assign wr_acc = i_wr_dv & ~o_full;
  assign rd_acc = i_rd_en & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_dv_q <= 1'b0;
    end else begin
      rd_dv_q <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A read accepted just before reset never surfaces as valid data.
  assign o_rd_dv = rd_dv_q & ~i_rst;

  RAM_2Port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_wr_clk  (i_clk),
    .i_wr_en   (wr_acc & ~i_rst),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_clk  (i_clk),
    .i_rd_rst  (i_rst),
    .i_rd_en   (rd_acc & ~i_rst),
    .i_rd_addr (rd_ptr),
    .o_rd_data (o_rd_data)
  );

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  // Sticky error flags: set by a dropped write or ignored read, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_dv && o_full) begin
        o_overflow <= 1'b1;
      end
      if (i_rd_en && o_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end
`else
  // Error tracking is not built in this configuration.
`endif

endmodule
